// File: rtl/hyper_aw_splitter_pkg.sv
// rtl/hyper_aw_splitter_pkg.sv - shared types for the HyperBus write burst splitter
package hyper_aw_splitter_pkg;

    typedef logic [8:0] piece_len_t;

    localparam int unsigned IdW = 6;

    typedef struct packed {
        logic           final_piece;
        logic [IdW-1:0] id;
    } b_entry_t;

    localparam logic [1:0] RespOkay = 2'b00;

    typedef enum logic {
        AwIdle,
        AwSplit
    } aw_state_e;

    function automatic piece_len_t min_len(input piece_len_t a, input piece_len_t b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/fifo_v3.sv
// rtl/fifo_v3.sv - small synchronous FIFO used as the piece tracker
module fifo_v3 #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]         count_q;
    logic                  do_push, do_pop;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == (PtrW + 1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/hyper_aw_splitter.sv
// rtl/hyper_aw_splitter.sv - splits INCR write bursts at page boundaries and a runtime length cap
module hyper_aw_splitter
    import hyper_aw_splitter_pkg::*;
#(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned IdWidth       = IdW,
    parameter int unsigned DataWidth     = 64,
    parameter int unsigned BoundaryBytes = 1024,
    parameter int unsigned MaxPieces     = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [7:0]             cfg_max_len_i,
    input  logic [AddrWidth-1:0]   aw_addr_i,
    input  logic [7:0]             aw_len_i,
    input  logic [2:0]             aw_size_i,
    input  logic [IdWidth-1:0]     aw_id_i,
    input  logic                   aw_valid_i,
    output logic                   aw_ready_o,
    input  logic [DataWidth-1:0]   w_data_i,
    input  logic [DataWidth/8-1:0] w_strb_i,
    input  logic                   w_valid_i,
    output logic                   w_ready_o,
    output logic [1:0]             b_resp_o,
    output logic [IdWidth-1:0]     b_id_o,
    output logic                   b_valid_o,
    input  logic                   b_ready_i,
    output logic [AddrWidth-1:0]   aw_addr_o,
    output logic [7:0]             aw_len_o,
    output logic [2:0]             aw_size_o,
    output logic [IdWidth-1:0]     aw_id_o,
    output logic                   aw_valid_o,
    input  logic                   aw_ready_i,
    output logic [DataWidth-1:0]   w_data_o,
    output logic [DataWidth/8-1:0] w_strb_o,
    output logic                   w_last_o,
    output logic                   w_valid_o,
    input  logic                   w_ready_i,
    input  logic [1:0]             b_resp_i,
    input  logic [IdWidth-1:0]     b_id_i,
    input  logic                   b_valid_i,
    output logic                   b_ready_o
);

    aw_state_e             state_q;
    logic [AddrWidth-1:0]  addr_q;
    logic [2:0]            size_q;
    logic [IdWidth-1:0]    id_q;
    piece_len_t            remaining_q, max_q;

    logic [AddrWidth-1:0]  room_bytes, room_beats;
    piece_len_t            room_len, beats, piece_len;
    logic                  piece_hs, w_hs, bi_hs;

    logic                  w_full, w_empty, b_full, b_empty;
    piece_len_t            w_head_len, beat_cnt_q;
    b_entry_t              b_push_data, b_head;
    logic [1:0]            err_q;
    logic                  unused_b_id;

    assign room_bytes = AddrWidth'(BoundaryBytes) - (addr_q & AddrWidth'(BoundaryBytes - 1));
    assign room_beats = room_bytes >> size_q;
    // Narrow beats fit more than a whole burst into one page; saturate to the 9-bit range.
    assign room_len   = (room_beats > AddrWidth'(256)) ? 9'd256 : room_beats[8:0];
    assign beats      = min_len(min_len(remaining_q, room_len), max_q);
    assign piece_len  = beats - 9'd1;

    assign aw_ready_o = rst_ni && (state_q == AwIdle) && !w_full && !b_full;
    assign aw_valid_o = (state_q == AwSplit) && !w_full && !b_full;
    assign aw_addr_o  = addr_q;
    assign aw_len_o   = piece_len[7:0];
    assign aw_size_o  = size_q;
    assign aw_id_o    = id_q;
    assign piece_hs   = aw_valid_o & aw_ready_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= AwIdle;
            addr_q      <= '0;
            size_q      <= '0;
            id_q        <= '0;
            remaining_q <= '0;
            max_q       <= '0;
        end else begin
            case (state_q)
                AwIdle: begin
                    if (aw_valid_i && aw_ready_o) begin
                        addr_q      <= aw_addr_i;
                        size_q      <= aw_size_i;
                        id_q        <= aw_id_i;
                        remaining_q <= {1'b0, aw_len_i} + 9'd1;
                        max_q       <= {1'b0, cfg_max_len_i} + 9'd1;
                        state_q     <= AwSplit;
                    end
                end
                AwSplit: begin
                    if (piece_hs) begin
                        addr_q      <= addr_q + (AddrWidth'(beats) << size_q);
                        remaining_q <= remaining_q - beats;
                        if (remaining_q == beats) state_q <= AwIdle;
                    end
                end
                default: state_q <= AwIdle;
            endcase
        end
    end

    // W beats pass straight through but are held off until their piece has been issued.
    assign w_data_o  = w_data_i;
    assign w_strb_o  = w_strb_i;
    assign w_valid_o = w_valid_i & ~w_empty;
    assign w_ready_o = w_ready_i & ~w_empty;
    assign w_last_o  = ~w_empty & (beat_cnt_q == w_head_len);
    assign w_hs      = w_valid_i & w_ready_i & ~w_empty;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            beat_cnt_q <= '0;
        end else if (w_hs) begin
            beat_cnt_q <= w_last_o ? '0 : beat_cnt_q + 9'd1;
        end
    end

    fifo_v3 #(
        .DATA_WIDTH ($bits(piece_len_t)),
        .DEPTH      (MaxPieces)
    ) i_w_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (1'b0),
        .full_o  (w_full),
        .empty_o (w_empty),
        .data_i  (piece_len),
        .push_i  (piece_hs),
        .data_o  (w_head_len),
        .pop_i   (w_hs & w_last_o)
    );

    assign b_push_data.final_piece = (remaining_q == beats);
    assign b_push_data.id          = id_q;

    fifo_v3 #(
        .DATA_WIDTH ($bits(b_entry_t)),
        .DEPTH      (MaxPieces)
    ) i_b_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (1'b0),
        .full_o  (b_full),
        .empty_o (b_empty),
        .data_i  (b_push_data),
        .push_i  (piece_hs),
        .data_o  (b_head),
        .pop_i   (bi_hs)
    );

    // Intermediate responses are swallowed; only the final piece reaches upstream.
    assign b_ready_o   = ~b_empty & (~b_head.final_piece | b_ready_i);
    assign b_valid_o   = b_valid_i & ~b_empty & b_head.final_piece;
    assign b_resp_o    = (err_q != RespOkay) ? err_q : b_resp_i;
    assign b_id_o      = b_head.id;
    assign bi_hs       = b_valid_i & b_ready_o;
    assign unused_b_id = ^b_id_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_q <= RespOkay;
        end else if (bi_hs) begin
            if (b_head.final_piece)     err_q <= RespOkay;
            else if (err_q == RespOkay) err_q <= b_resp_i;
        end
    end

endmodule

// File: tb/tb_hyper_aw_splitter.sv
// tb/tb_hyper_aw_splitter.sv - directed bench for the write burst splitter
module tb_hyper_aw_splitter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [7:0]  cfg_max_len_i;
    logic [31:0] aw_addr_i;
    logic [7:0]  aw_len_i;
    logic [2:0]  aw_size_i;
    logic [5:0]  aw_id_i;
    logic        aw_valid_i, aw_ready_o;
    logic [63:0] w_data_i;
    logic [7:0]  w_strb_i;
    logic        w_valid_i, w_ready_o;
    logic [1:0]  b_resp_o;
    logic [5:0]  b_id_o;
    logic        b_valid_o, b_ready_i;
    logic [31:0] aw_addr_o;
    logic [7:0]  aw_len_o;
    logic [2:0]  aw_size_o;
    logic [5:0]  aw_id_o;
    logic        aw_valid_o, aw_ready_i;
    logic [63:0] w_data_o;
    logic [7:0]  w_strb_o;
    logic        w_last_o, w_valid_o, w_ready_i;
    logic [1:0]  b_resp_i;
    logic [5:0]  b_id_i;
    logic        b_valid_i, b_ready_o;

    always #5 clk_i = ~clk_i;

    hyper_aw_splitter dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .cfg_max_len_i(cfg_max_len_i),
        .aw_addr_i(aw_addr_i), .aw_len_i(aw_len_i), .aw_size_i(aw_size_i), .aw_id_i(aw_id_i),
        .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o),
        .w_data_i(w_data_i), .w_strb_i(w_strb_i), .w_valid_i(w_valid_i), .w_ready_o(w_ready_o),
        .b_resp_o(b_resp_o), .b_id_o(b_id_o), .b_valid_o(b_valid_o), .b_ready_i(b_ready_i),
        .aw_addr_o(aw_addr_o), .aw_len_o(aw_len_o), .aw_size_o(aw_size_o), .aw_id_o(aw_id_o),
        .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
        .w_data_o(w_data_o), .w_strb_o(w_strb_o), .w_last_o(w_last_o),
        .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
        .b_resp_i(b_resp_i), .b_id_i(b_id_i), .b_valid_i(b_valid_i), .b_ready_o(b_ready_o)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] pa_q[$];
    logic [7:0]  pl_q[$];
    logic        wl_q[$];
    logic [63:0] wd_q[$];
    logic [1:0]  br_q[$];
    logic [5:0]  bid_q[$];
    logic [1:0]  resp_plan[$];
    int          pending_b = 0;
    logic        b_hs = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pa_at(input int i);
        return (i < pa_q.size()) ? 64'(pa_q[i]) : 64'hDEAD;
    endfunction
    function automatic logic [63:0] pl_at(input int i);
        return (i < pl_q.size()) ? 64'(pl_q[i]) : 64'hDEAD;
    endfunction
    function automatic logic [63:0] wd_at(input int i);
        return (i < wd_q.size()) ? wd_q[i] : 64'hDEAD;
    endfunction
    function automatic logic [63:0] br_at(input int i);
        return (i < br_q.size()) ? 64'(br_q[i]) : 64'hDEAD;
    endfunction
    function automatic logic [63:0] bid_at(input int i);
        return (i < bid_q.size()) ? 64'(bid_q[i]) : 64'hDEAD;
    endfunction
    function automatic logic [63:0] wl_bits();
        logic [63:0] v = '0;
        for (int i = 0; i < wl_q.size() && i < 64; i++) v[i] = wl_q[i];
        return v;
    endfunction

    // Downstream observer: records every handshake just before the edge that completes it.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (aw_valid_o && aw_ready_i) begin
                pa_q.push_back(aw_addr_o);
                pl_q.push_back(aw_len_o);
                pending_b++;
            end
            if (w_valid_o && w_ready_i) begin
                wl_q.push_back(w_last_o);
                wd_q.push_back(w_data_o);
            end
            if (b_valid_o && b_ready_i) begin
                br_q.push_back(b_resp_o);
                bid_q.push_back(b_id_o);
            end
            if (b_valid_i && b_ready_o) begin
                pending_b--;
                b_hs = 1'b1;
            end
        end
    end

    // Frontend B model: one response per issued piece, resp taken from resp_plan.
    always @(posedge clk_i) begin
        #1;
        if (!rst_ni) begin
            b_valid_i = 1'b0;
        end else begin
            if (b_hs) begin
                b_valid_i = 1'b0;
                b_hs = 1'b0;
            end
            if (!b_valid_i && pending_b > 0) begin
                b_valid_i = 1'b1;
                b_resp_i  = (resp_plan.size() > 0) ? resp_plan.pop_front() : 2'b00;
            end
        end
    end

    task automatic clear_log();
        pa_q.delete(); pl_q.delete(); wl_q.delete(); wd_q.delete();
        br_q.delete(); bid_q.delete();
    endtask

    task automatic send_aw(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                           input logic [5:0] id, input logic [7:0] cfg);
        bit ok = 0;
        aw_addr_i = a; aw_len_i = l; aw_size_i = s; aw_id_i = id; cfg_max_len_i = cfg;
        aw_valid_i = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk_i);
            if (aw_ready_o) begin ok = 1; break; end
        end
        if (!ok) check("aw_accept_timeout", 64'd0, 64'd1);
        @(posedge clk_i); #1;
        aw_valid_i = 1'b0;
    endtask

    task automatic send_w(input int beats, input logic [63:0] base);
        for (int i = 0; i < beats; i++) begin
            bit ok = 0;
            w_data_i = base + 64'(i); w_strb_i = 8'hFF; w_valid_i = 1'b1;
            for (int n = 0; n < 200; n++) begin
                @(negedge clk_i);
                if (w_ready_o) begin ok = 1; break; end
            end
            if (!ok) check("w_accept_timeout", 64'd0, 64'd1);
            @(posedge clk_i); #1;
        end
        w_valid_i = 1'b0;
    endtask

    task automatic wait_b(input int n);
        for (int c = 0; c < 300 && br_q.size() < n; c++) @(negedge clk_i);
        check("b_count", 64'(br_q.size()), 64'(n));
        @(posedge clk_i); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0; cfg_max_len_i = 8'd255;
        aw_addr_i = '0; aw_len_i = '0; aw_size_i = '0; aw_id_i = '0; aw_valid_i = 1'b0;
        w_data_i = '0; w_strb_i = '0; w_valid_i = 1'b0;
        b_ready_i = 1'b1; aw_ready_i = 1'b1; w_ready_i = 1'b1;
        b_resp_i = '0; b_id_i = '0; b_valid_i = 1'b0;

        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_aw_ready", 64'(aw_ready_o), 64'd0);
        check("rst_aw_valid", 64'(aw_valid_o), 64'd0);
        check("rst_w_valid",  64'(w_valid_o),  64'd0);
        check("rst_w_ready",  64'(w_ready_o),  64'd0);
        check("rst_w_last",   64'(w_last_o),   64'd0);
        check("rst_b_valid",  64'(b_valid_o),  64'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("post_rst_aw_ready", 64'(aw_ready_o), 64'd1);
        @(posedge clk_i); #1;

        // Page crossing: 0x3F0 + 4x8 bytes spans the 1 KiB boundary.
        clear_log();
        send_aw(32'h8000_03F0, 8'd3, 3'd3, 6'd5, 8'd255);
        send_w(4, 64'hA000);
        wait_b(1);
        check("t1_pieces",  64'(pa_q.size()), 64'd2);
        check("t1_addr0",   pa_at(0), 64'h8000_03F0);
        check("t1_len0",    pl_at(0), 64'd1);
        check("t1_addr1",   pa_at(1), 64'h8000_0400);
        check("t1_len1",    pl_at(1), 64'd1);
        check("t1_wlast",   wl_bits(), 64'b1010);
        check("t1_data3",   wd_at(3), 64'hA003);
        check("t1_bresp",   br_at(0), 64'd0);
        check("t1_bid",     bid_at(0), 64'd5);

        // Length cap of 4 beats.
        clear_log();
        send_aw(32'h8000_0000, 8'd15, 3'd3, 6'd12, 8'd3);
        send_w(16, 64'hB000);
        wait_b(1);
        check("t2_pieces",  64'(pa_q.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_addr%0d", i), pa_at(i), 64'h8000_0000 + 64'(i * 32));
            check($sformatf("t2_len%0d", i),  pl_at(i), 64'd3);
        end
        check("t2_wlast",   wl_bits(), 64'h8888);
        check("t2_bid",     bid_at(0), 64'd12);

        // Error merge: OKAY, SLVERR, OKAY collapse to one SLVERR.
        clear_log();
        resp_plan.push_back(2'b00); resp_plan.push_back(2'b10); resp_plan.push_back(2'b00);
        send_aw(32'h8000_0000, 8'd5, 3'd3, 6'h2A, 8'd1);
        send_w(6, 64'hD000);
        wait_b(1);
        check("t3_pieces",  64'(pa_q.size()), 64'd3);
        check("t3_bresp",   br_at(0), 64'd2);
        check("t3_bid",     bid_at(0), 64'h2A);

        // Next burst starts with a clean error state.
        clear_log();
        send_aw(32'h8000_1000, 8'd0, 3'd2, 6'd3, 8'd255);
        send_w(1, 64'hE000);
        wait_b(1);
        check("t4_pieces",  64'(pa_q.size()), 64'd1);
        check("t4_addr",    pa_at(0), 64'h8000_1000);
        check("t4_len",     pl_at(0), 64'd0);
        check("t4_wlast",   wl_bits(), 64'b1);
        check("t4_bresp",   br_at(0), 64'd0);

        // Frontend stalls AW for 5 cycles after the first piece; W is offered early.
        clear_log();
        fork
            begin
                send_aw(32'h8000_03F0, 8'd3, 3'd3, 6'd17, 8'd255);
                send_w(4, 64'hC000);
            end
            begin
                for (int n = 0; n < 100 && pa_q.size() < 1; n++) begin
                    @(posedge clk_i); #1;
                end
                aw_ready_i = 1'b0;
                repeat (3) @(posedge clk_i);
                @(negedge clk_i);
                check("t5_stall_w_ready", 64'(w_ready_o), 64'd0);
                check("t5_stall_pieces",  64'(pa_q.size()), 64'd1);
                repeat (2) @(posedge clk_i);
                #1 aw_ready_i = 1'b1;
            end
        join
        wait_b(1);
        check("t5_pieces",  64'(pa_q.size()), 64'd2);
        check("t5_addr1",   pa_at(1), 64'h8000_0400);
        check("t5_wcount",  64'(wd_q.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("t5_data%0d", i), wd_at(i), 64'hC000 + 64'(i));
        check("t5_wlast",   wl_bits(), 64'b1010);
        check("t5_bid",     bid_at(0), 64'd17);

        // Reset while the second piece is pending.
        clear_log();
        aw_ready_i = 1'b0;
        send_aw(32'h8000_03F0, 8'd3, 3'd3, 6'd7, 8'd255);
        aw_ready_i = 1'b1;
        @(posedge clk_i); #1;
        aw_ready_i = 1'b0;
        @(negedge clk_i);
        check("t6_piece2_valid", 64'(aw_valid_o), 64'd1);
        check("t6_piece2_addr",  64'(aw_addr_o), 64'h8000_0400);
        @(posedge clk_i); #2;
        rst_ni = 1'b0;
        @(negedge clk_i);
        check("t6_rst_aw_ready", 64'(aw_ready_o), 64'd0);
        @(posedge clk_i); #2;
        pending_b = 0; b_hs = 1'b0; b_valid_i = 1'b0; resp_plan.delete();
        clear_log();
        rst_ni = 1'b1; aw_ready_i = 1'b1;
        @(negedge clk_i);
        check("t6_aw_valid", 64'(aw_valid_o), 64'd0);
        check("t6_w_valid",  64'(w_valid_o),  64'd0);
        check("t6_b_valid",  64'(b_valid_o),  64'd0);
        check("t6_aw_ready", 64'(aw_ready_o), 64'd1);
        @(posedge clk_i); #1;
        send_aw(32'h8000_0000, 8'd1, 3'd3, 6'd9, 8'd255);
        send_w(2, 64'hF000);
        wait_b(1);
        check("t6_pieces",  64'(pa_q.size()), 64'd1);
        check("t6_len",     pl_at(0), 64'd1);
        check("t6_wlast",   wl_bits(), 64'b10);
        check("t6_bresp",   br_at(0), 64'd0);
        check("t6_bid",     bid_at(0), 64'd9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
